mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single unified instruction/data memory between two requesters: port 0 = multicycle CPU, port 1 = DMA/loader.
//  Round-robin grant, one access in flight, fixed memory latency.
//  Sits between the CPU memory interface (mem_read/mem_write/IorD address) and the memory.
//  Requesters wait on their ack; the CPU stalls its controller FSM until ack_cpu.
// PARAMETERS
//  ADDR_W   32  address width, bytes
//  DATA_W   32  data width
//  MEM_LAT  2   memory access latency in cycles, legal range 1..15
// PORTS
//  clk          in   1       clock, all logic on posedge
//  rst          in   1       reset, synchronous, active-low
//  cpu_req      in   1       CPU access request, held until ack_cpu
//  cpu_we       in   1       1 = write, 0 = read
//  cpu_addr     in   ADDR_W  CPU address
//  cpu_wdata    in   DATA_W  CPU write data
//  ack_cpu      out  1       one-cycle pulse: CPU access complete
//  dma_req      in   1       DMA request, held until ack_dma
//  dma_we       in   1       1 = write, 0 = read
//  dma_addr     in   ADDR_W  DMA address
//  dma_wdata    in   DATA_W  DMA write data
//  ack_dma      out  1       one-cycle pulse: DMA access complete
//  rdata        out  DATA_W  read data, valid while ack_* is high
//  grant        out  1       owner of the current/last access: 0 = CPU, 1 = DMA
//  busy         out  1       high in ACCESS or DONE
//  mem_read     out  1       memory read strobe
//  mem_write    out  1       memory write strobe
//  mem_addr     out  ADDR_W  memory address
//  mem_wdata    out  DATA_W  memory write data
//  mem_rdata    in   DATA_W  memory read data, valid in the last ACCESS cycle
// BEHAVIOUR
//  Reset (rst==0 at posedge):
//   - state=IDLE, cnt=0, last_grant=1 (CPU wins the first tie).
//   - All outputs 0.
//   - An in-flight access is aborted: no ack, strobes drop the next cycle.
//  All outputs are registered.
//  FSM IDLE -> ACCESS -> DONE -> IDLE:
//   IDLE:
//    - No request: stay.
//    - Any request: pick a winner, latch its we/addr/wdata into mem_*, set grant=winner, last_grant=winner,
//      cnt=MEM_LAT-1, go ACCESS.
//   ACCESS:
//    - mem_read=!we or mem_write=we, held high for exactly MEM_LAT cycles.
//    - mem_addr/mem_wdata are stable throughout.
//    - cnt decrements each cycle. At cnt==0: capture mem_rdata into rdata on reads (rdata unchanged on writes),
//      drop the strobes, go DONE.
//   DONE: ack_<grant>=1 for one cycle, then go IDLE.
//  Arbitration:
//   - Only one requester: it wins.
//   - Both requesting: the port != last_grant wins (strict alternation under contention).
//  Latency and throughput:
//   - req sampled at edge E0 -> strobes high E0..E0+MEM_LAT -> ack high one cycle, starting at edge E0+MEM_LAT+1.
//   - Peak throughput is one access per MEM_LAT+2 cycles.
//  Handshake rules:
//   - Requester deasserts req in its ack cycle.
//   - req still high when IDLE next samples = a new request.
//   - req or inputs changing after grant have no effect on the access in flight.
//   - req dropped before ack: the access still completes and ack still pulses.
//  busy=1 in ACCESS and DONE. ack_cpu and ack_dma are never high together.
//  MEM_LAT=1: ACCESS lasts one cycle, cnt initial value 0.
// STRUCTURE
//  mem_arb_pkg: state encodings (IDLE=2'b00, ACCESS=2'b01, DONE=2'b10), PORT_CPU=1'b0, PORT_DMA=1'b1, CNT_W=4.
//  One sub-module, mem_arb_rr_pick: combinational 2-way round-robin picker.
//   - Inputs: req[1:0], last_grant.
//   - Outputs: winner, any_req.
//  Top level holds the FSM, latency counter and command/rdata registers.
// TESTING
//  - Reset: hold rst=0 for 3 cycles with both req high -> all outputs 0, no strobes.
//    After release the first grant is 0 (CPU).
//  - CPU read, MEM_LAT=2: cpu_addr=0x40, memory returns 0xDEADBEEF -> mem_read high 2 cycles,
//    ack_cpu 3 cycles after the sampling edge, rdata=0xDEADBEEF.
//  - DMA write: addr 0x100, data 0x12345678 -> mem_write high 2 cycles with stable addr/data, ack_dma pulse,
//    rdata unchanged.
//  - Contention: both req held continuously for 4 accesses -> grants 0,1,0,1, each ack one cycle,
//    acks never overlap.
//  - Mid-access reset: rst=0 during the second ACCESS cycle -> strobes low next cycle, no ack,
//    next grant goes to the CPU.
//  - Req dropped early: cpu_req falls one cycle after grant -> access completes, ack_cpu still pulses,
//    FSM returns to IDLE.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared encodings and sizes for the two-port memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    DONE   = 2'b10
  } arb_state_t;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

  // Latency counter width; MEM_LAT up to 15 fits.
  localparam int CNT_W = 4;

endpackage

// File: rtl/mem_arb_rr_pick.sv
// Combinational 2-way round-robin picker: a lone requester wins,
// on a tie the port that did not win last time gets the grant.
module mem_arb_rr_pick
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       winner,
  output logic       any_req
);

  // Pick the winner from the current request pair and the previous owner
  always_comb begin
    any_req = |req;
    if (req[PORT_CPU] && req[PORT_DMA]) winner = ~last_grant;
    else if (req[PORT_DMA])             winner = PORT_DMA;
    else                                winner = PORT_CPU;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one unified memory between the CPU (port 0) and the DMA/loader
// (port 1). One access in flight, fixed latency, all outputs registered.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              ack_cpu,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              ack_dma,
  output logic [DATA_W-1:0] rdata,
  output logic              grant,
  output logic              busy,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LAT - 1);

  arb_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_grant_q, last_grant_d;
  logic             winner, any_req;

  logic              ack_cpu_d, ack_dma_d, grant_d, busy_d;
  logic              mem_read_d, mem_write_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_d, rdata_d;

  mem_arb_rr_pick u_pick (
    .req        ({dma_req, cpu_req}),
    .last_grant (last_grant_q),
    .winner     (winner),
    .any_req    (any_req)
  );

  // State, counter and round-robin history; reset aborts any access
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      last_grant_q <= PORT_DMA;   // so the CPU wins the first tie
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Next-state: grant from IDLE, count out the latency, one DONE cycle
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d      = ACCESS;
          cnt_d        = CNT_INIT;
          last_grant_d = winner;
        end
      end
      ACCESS: begin
        if (cnt_q == '0) state_d = DONE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs; command fields hold unless granted
  always_comb begin
    ack_cpu_d   = 1'b0;
    ack_dma_d   = 1'b0;
    grant_d     = grant;
    mem_read_d  = mem_read;
    mem_write_d = mem_write;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    rdata_d     = rdata;
    busy_d      = (state_d != IDLE);
    case (state_q)
      IDLE: begin
        if (any_req) begin
          // Latch the winner's command; later input changes cannot disturb it
          grant_d     = winner;
          mem_addr_d  = (winner == PORT_DMA) ? dma_addr  : cpu_addr;
          mem_wdata_d = (winner == PORT_DMA) ? dma_wdata : cpu_wdata;
          mem_write_d = (winner == PORT_DMA) ? dma_we    : cpu_we;
          mem_read_d  = ~mem_write_d;
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          // Memory data is valid in this last strobe cycle
          if (mem_read) rdata_d = mem_rdata;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
        end
      end
      DONE: begin
        ack_cpu_d = (grant == PORT_CPU);
        ack_dma_d = (grant == PORT_DMA);
      end
      default: ;
    endcase
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      ack_cpu   <= 1'b0;
      ack_dma   <= 1'b0;
      grant     <= 1'b0;
      busy      <= 1'b0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rdata     <= '0;
    end else begin
      ack_cpu   <= ack_cpu_d;
      ack_dma   <= ack_dma_d;
      grant     <= grant_d;
      busy      <= busy_d;
      mem_read  <= mem_read_d;
      mem_write <= mem_write_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      rdata     <= rdata_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus
// randomized transactions against a transaction-level timing model.
module tb_mem_port_arbiter;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we, dma_req, dma_we;
  logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
  logic        ack_cpu, ack_dma, grant, busy, mem_read, mem_write;
  logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: previous owner and last read data delivered
  bit          lg;
  logic [31:0] exp_rdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .ack_cpu(ack_cpu),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .ack_dma(ack_dma),
    .rdata(rdata), .grant(grant), .busy(busy),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // {ack_cpu, ack_dma, busy, grant, mem_read, mem_write}
  function automatic logic [5:0] ctl();
    return {ack_cpu, ack_dma, busy, grant, mem_read, mem_write};
  endfunction

  // One complete access starting at the next edge. Timeline from the spec:
  // strobes for LAT cycles after the sampling edge, ack in the cycle after that.
  task automatic run_txn(input string nm, input bit c, input bit d,
                         input bit cw, input logic [31:0] ca, input logic [31:0] cd,
                         input bit dw, input logic [31:0] da, input logic [31:0] dd,
                         input logic [31:0] md, input bit drop);
    bit w, we;
    logic [31:0] a, wd;
    logic [5:0] exp_ctl;
    w  = (c && d) ? !lg : d;
    we = w ? dw : cw;
    a  = w ? da : ca;
    wd = w ? dd : cd;
    cpu_req = c; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    dma_req = d; dma_we = dw; dma_addr = da; dma_wdata = dd;
    mem_rdata = $urandom;
    if (LAT == 1) mem_rdata = md;
    for (int i = 0; i <= LAT + 1; i++) begin
      @(posedge clk); #1;
      if (i < LAT)       exp_ctl = {1'b0, 1'b0, 1'b1, w, !we, we};
      else if (i == LAT) exp_ctl = {1'b0, 1'b0, 1'b1, w, 1'b0, 1'b0};
      else               exp_ctl = {!w, w, 1'b0, w, 1'b0, 1'b0};
      if (i == LAT && !we) exp_rdata = md;
      n_cmp++;
      if (ctl() !== exp_ctl) begin
        n_bad++;
        $display("FAIL %s ctl cyc%0d: got %b want %b (ack_c,ack_d,busy,grant,rd,wr)", nm, i, ctl(), exp_ctl);
      end
      n_cmp++;
      if (mem_addr !== a || mem_wdata !== wd) begin
        n_bad++;
        $display("FAIL %s cmd cyc%0d: got addr %h data %h want addr %h data %h", nm, i, mem_addr, mem_wdata, a, wd);
      end
      n_cmp++;
      if (rdata !== exp_rdata) begin
        n_bad++;
        $display("FAIL %s rdata cyc%0d: got %h want %h", nm, i, rdata, exp_rdata);
      end
      // Disturb the inputs after the grant; the access must not notice
      cpu_addr = $urandom; dma_addr = $urandom; cpu_wdata = $urandom; dma_wdata = $urandom;
      cpu_we = 1'($urandom); dma_we = 1'($urandom);
      if (i == 0 && drop) begin
        if (w) dma_req = 1'b0; else cpu_req = 1'b0;
      end
      mem_rdata = (i == LAT - 1) ? md : $urandom;
    end
    cpu_req = 1'b0;
    dma_req = 1'b0;
    lg = w;
  endtask

  task automatic test_reset();
    rst = 1'b0; cpu_req = 1'b1; dma_req = 1'b1;
    cpu_we = 1'b0; dma_we = 1'b1; cpu_addr = 32'h4; dma_addr = 32'h8;
    cpu_wdata = 32'h1; dma_wdata = 32'h2; mem_rdata = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (ctl() !== 6'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0 || rdata !== 32'h0) begin
        n_bad++;
        $display("FAIL reset cyc%0d: got ctl %b addr %h wdata %h rdata %h want all zero", i, ctl(), mem_addr, mem_wdata, rdata);
      end
    end
    rst = 1'b1; lg = 1'b1; exp_rdata = 32'h0;
    run_txn("first_grant", 1, 1, 0, 32'h10, 32'h0, 0, 32'h20, 32'h0, 32'hA5A5_0001, 0);
  endtask

  task automatic test_idle();
    bit g;
    g = lg;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (ctl() !== {4'b0000 | {3'b000, g}, 2'b00}) begin
        n_bad++;
        $display("FAIL idle cyc%0d: got ctl %b want %b", i, ctl(), {3'b000, g, 2'b00});
      end
    end
  endtask

  task automatic test_cpu_read();
    run_txn("cpu_read", 1, 0, 0, 32'h40, 32'h0, 0, 32'h0, 32'h0, 32'hDEAD_BEEF, 0);
  endtask

  task automatic test_dma_write();
    run_txn("dma_write", 0, 1, 0, 32'h0, 32'h0, 1, 32'h100, 32'h1234_5678, 32'h0BAD_0BAD, 0);
  endtask

  task automatic test_contention();
    for (int k = 0; k < 4; k++)
      run_txn($sformatf("contend%0d", k), 1, 1, 0, 32'h200 + k, 32'h0, 0, 32'h300 + k, 32'h0, $urandom, 0);
  endtask

  task automatic test_mid_reset();
    run_txn("pre_abort", 0, 1, 0, 32'h0, 32'h0, 0, 32'h50, 32'h0, 32'h7777_0000, 0);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h80; dma_req = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (mem_read !== 1'b1 || grant !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_start: got rd %b grant %b want rd 1 grant 0", mem_read, grant);
    end
    @(posedge clk); #1;
    rst = 1'b0; dma_req = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (ctl() !== 6'b0 || rdata !== 32'h0 || mem_addr !== 32'h0) begin
        n_bad++;
        $display("FAIL abort cyc%0d: got ctl %b rdata %h addr %h want zero", i, ctl(), rdata, mem_addr);
      end
    end
    rst = 1'b1; lg = 1'b1; exp_rdata = 32'h0;
    run_txn("post_abort", 1, 1, 0, 32'h90, 32'h0, 0, 32'hA0, 32'h0, 32'h1357_9BDF, 0);
  endtask

  task automatic test_drop_early();
    run_txn("drop_cpu", 1, 0, 0, 32'hC0, 32'h0, 0, 32'h0, 32'h0, 32'h2468_ACE0, 1);
    test_idle();
  endtask

  task automatic test_random();
    bit c, d;
    for (int k = 0; k < 40; k++) begin
      c = 1'($urandom); d = 1'($urandom);
      if (!c && !d) c = 1'b1;
      run_txn($sformatf("rand%0d", k), c, d,
              1'($urandom), $urandom, $urandom, 1'($urandom), $urandom, $urandom,
              $urandom, 1'($urandom));
      if ($urandom_range(0, 2) == 0) test_idle();
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_cpu_read();
    test_dma_write();
    test_contention();
    test_mid_reset();
    test_drop_early();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
